// File: rtl/miriscv_arb_pkg.sv
// rtl/miriscv_arb_pkg.sv - shared types and constants for the data-port arbiter
package miriscv_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int N_MASTERS = 2;
    localparam int MST_LSU   = 0;
    localparam int MST_DMA   = 1;

endpackage

// File: rtl/miriscv_rr_arb2.sv
// rtl/miriscv_rr_arb2.sv - combinational two-way grant selection from request and priority pointer
module miriscv_rr_arb2
    import miriscv_arb_pkg::*;
(
    input  logic [N_MASTERS-1:0] req,
    input  logic                 prio,
    output logic [N_MASTERS-1:0] gnt
);

    // A lone requester always wins; on contention the master named by prio wins.
    always_comb begin
        gnt          = '0;
        gnt[MST_LSU] = req[MST_LSU] & (~req[MST_DMA] | ~prio);
        gnt[MST_DMA] = req[MST_DMA] & (~req[MST_LSU] |  prio);
    end

endmodule

// File: rtl/miriscv_data_arb.sv
// rtl/miriscv_data_arb.sv - two-master round-robin arbiter with DMA lock in front of the RAM data port
module miriscv_data_arb
    import miriscv_arb_pkg::*;
#(
    parameter int RAM_SIZE = 256,
    parameter int LOCK_MAX = 16
) (
    input  logic                        clk,
    input  logic                        rst_n_i,
    input  logic [N_MASTERS-1:0]        m_req_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS-1:0][3:0]   m_be_i,
    input  logic [N_MASTERS-1:0][31:0]  m_addr_i,
    input  logic [N_MASTERS-1:0][31:0]  m_wdata_i,
    input  logic                        m1_lock_i,
    output logic [N_MASTERS-1:0]        m_gnt_o,
    output logic [N_MASTERS-1:0]        m_rvalid_o,
    output logic [N_MASTERS-1:0]        m_err_o,
    output logic [31:0]                 m_rdata_o,
    output logic                        data_req_o,
    output logic                        data_we_o,
    output logic [3:0]                  data_be_o,
    output logic [31:0]                 data_addr_o,
    output logic [31:0]                 data_wdata_o,
    input  logic [31:0]                 data_rdata_i
);

    localparam int               CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);
    localparam logic [31:0]      ADDR_LIMIT = 32'(RAM_SIZE);

    arb_state_e       state_q, state_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] lock_inc;
    logic             resp_valid_q;
    logic             resp_owner_q;
    logic             rsp_err_q;

    logic [N_MASTERS-1:0] rr_gnt;
    logic [N_MASTERS-1:0] gnt;
    logic                 any_gnt;
    logic                 sel;
    logic                 in_range;

    miriscv_rr_arb2 u_rr_arb2 (
        .req  (m_req_i),
        .prio (prio_q),
        .gnt  (rr_gnt)
    );

    // While locked only the DMA may be granted; reset suppresses every grant.
    always_comb begin
        gnt = '0;
        if (rst_n_i) begin
            if (state_q == LOCKED) begin
                gnt[MST_DMA] = m_req_i[MST_DMA];
            end else begin
                gnt = rr_gnt;
            end
        end
    end

    assign any_gnt  = |gnt;
    assign sel      = gnt[MST_DMA];
    assign in_range = m_addr_i[sel] < ADDR_LIMIT;
    assign lock_inc = lock_cnt_q + 1'b1;

    assign m_gnt_o      = gnt;
    assign data_req_o   = any_gnt & in_range;
    assign data_we_o    = data_req_o & m_we_i[sel];
    assign data_be_o    = any_gnt ? m_be_i[sel]    : 4'h0;
    assign data_addr_o  = any_gnt ? m_addr_i[sel]  : 32'h0;
    assign data_wdata_o = any_gnt ? m_wdata_i[sel] : 32'h0;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;
        if (any_gnt) begin
            prio_d = ~sel;
        end
        case (state_q)
            ARB: begin
                if (gnt[MST_DMA] && m1_lock_i) begin
                    lock_cnt_d = CNT_W'(1);
                    // A one-grant lock budget is exhausted by the locking grant itself.
                    if (LOCK_MAX == 1) begin
                        prio_d = 1'b0;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (gnt[MST_DMA]) begin
                    lock_cnt_d = lock_inc;
                end
                if (gnt[MST_DMA] && lock_inc == LOCK_LIMIT) begin
                    state_d = ARB;
                    prio_d  = 1'b0;
                end else if (!m1_lock_i) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state_q      <= ARB;
            prio_q       <= 1'b0;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= any_gnt;
            resp_owner_q <= sel;
            rsp_err_q    <= any_gnt & ~in_range;
        end
    end

    // Response for last cycle's grant lines up with the RAM's registered read data.
    always_comb begin
        m_rvalid_o               = '0;
        m_err_o                  = '0;
        m_rvalid_o[resp_owner_q] = resp_valid_q;
        m_err_o[resp_owner_q]    = resp_valid_q & rsp_err_q;
        m_rdata_o                = rsp_err_q ? 32'h0 : data_rdata_i;
    end

endmodule

// File: doc/miriscv_data_arb.md
Name: miriscv_data_arb

Overview:
- Two-master arbiter in front of the single data port of miriscv_ram.
- Master 0 is the core LSU. Master 1 is the loader/debug DMA.
- Provides a req/gnt/rvalid handshake per master and round-robin fairness.
- Master 1 can lock the port for multi-beat transfers.
- Out-of-range accesses are rejected so they never alias or corrupt RAM.

Parameters:
- RAM_SIZE, 256, RAM size in bytes; must be a power of two and at least 4; accesses with addr >= RAM_SIZE are errors.
- LOCK_MAX, 16, maximum consecutive grants to master 1 while locked before master 0 is forced in; must be at least 1.

Ports:
- clk  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- m_req_i  in  2  request per master (index 0 = LSU, 1 = DMA)
- m_we_i  in  2  write enable per master
- m_be_i  in  2x4  byte enables per master
- m_addr_i  in  2x32  byte address per master
- m_wdata_i  in  2x32  write data per master
- m1_lock_i  in  1  master 1 lock request
- m_gnt_o  out  2  grant; one-hot or zero; combinational
- m_rvalid_o  out  2  response valid, one cycle after grant
- m_err_o  out  2  error flag, qualified by rvalid
- m_rdata_o  out  32  read data, shared; qualified by m_rvalid_o
- data_req_o  out  1  to RAM data_req_i
- data_we_o  out  1  to RAM data_we_i
- data_be_o  out  4  to RAM data_be_i
- data_addr_o  out  32  to RAM data_addr_i
- data_wdata_o  out  32  to RAM data_wdata_i
- data_rdata_i  in  32  from RAM data_rdata_o (registered, 1-cycle latency)

Behaviour:
- Reset (rst_n_i=0 at a clk edge):
  - State becomes ARB and the priority pointer prio becomes 0.
  - lock_cnt, resp_owner and rsp_err are cleared; m_rvalid_o becomes 0.
  - While rst_n_i=0, m_gnt_o and data_req_o are forced to 0. A transaction granted in the same cycle is dropped with no response.
- Throughput: one grant per cycle; the RAM accepts every cycle, so there are no wait states.
- Grant in ARB state:
  - Only one master requesting: that master wins.
  - Both requesting: the master equal to prio wins.
  - After any grant, prio becomes the non-granted index.
- Master 1 lock:
  - Master 1 granted with m1_lock_i=1 moves the FSM ARB->LOCKED and sets lock_cnt=1.
  - In LOCKED, only master 1 may be granted; each grant increments lock_cnt.
  - Exit to ARB when m1_lock_i=0 is sampled, or when lock_cnt==LOCK_MAX is reached at a grant.
  - On a LOCK_MAX exit, prio is set to 0, so master 0 wins the next contention.
  - In LOCKED with m_req_i[1]=0, no grant is issued. Master 0 waits; there is no timeout other than m1_lock_i deassertion.
- Address check:
  - A granted access with addr >= RAM_SIZE is an error.
  - It is still granted, but data_req_o=0 and data_we_o=0 are driven.
  - Next cycle: rvalid=1, err=1, rdata=0.
  - Unaligned addresses are not errors; the RAM uses addr[31:2].
- Forwarding:
  - data_* is the combinational mux of the granted master.
  - With no grant: data_req_o=0 and the other data_* outputs are 0.
  - data_req_o = grant AND in-range.
- Response:
  - A grant in cycle N registers resp_owner and rsp_err.
  - In cycle N+1: m_rvalid_o[owner]=1 for exactly one cycle, m_err_o[owner]=rsp_err, m_rdata_o = rsp_err ? 0 : data_rdata_i.
  - Writes also get rvalid (ack); m_rdata_o is don't-care for writes but must equal data_rdata_i.
  - Back-to-back grants give back-to-back rvalids, in order.
  - A request/grant in cycle N+1 coexists with the response to cycle N.
- Masters must hold req and signals stable until gnt. Request withdrawal before gnt is legal; no state change results.

Decomposition:
- Package miriscv_arb_pkg: typedef arb_state_e {ARB, LOCKED}; localparam N_MASTERS=2; localparam MST_LSU=0, MST_DMA=1.
- Sub-module miriscv_rr_arb2: combinational 2-way grant from req and prio. The top holds the FSM, lock_cnt, prio register and response pipeline.

Test Plan:
- Simultaneous reads (m0 addr 0x10, m1 addr 0x20) after reset -> gnt=01 at cycle N, gnt=10 at N+1; rvalid[0] at N+1 with mem[4], rvalid[1] at N+2 with mem[8].
- m0 write 0xDEADBEEF be=1111 to 0x8, then m1 read 0x8 next cycle -> m1 rdata=0xDEADBEEF, err=0.
- m0 read 0x100 (RAM_SIZE=256) -> gnt[0]=1, data_req_o=0, next cycle rvalid[0]=1, err[0]=1, rdata=0; RAM contents unchanged.
- m1 lock held with continuous m1 req and m0 req -> m1 granted 16 consecutive cycles, then m0 granted at grant 17.
- m1 locked, m1 idle 3 cycles, m0 requesting -> no grants until m1_lock_i=0; then m0 granted the next cycle.
- rst_n_i=0 asserted the cycle after a grant -> no rvalid afterwards; after release, state ARB and prio=0 (both req -> m0 first).
